// File: rtl/mem_stage.sv
// mem_stage: RV32I MEM stage with word-organised data memory and MEM/WB register; MEM_BYTE_LANES_EN enables sub-word access
module mem_stage #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  rd,
    input  logic        reg_write,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic        mem_reg,
    input  logic [31:0] ex_mem_instruction,
    output logic [31:0] mem_data,
    output logic [31:0] mem_alu_result,
    output logic [4:0]  mem_rd,
    output logic        mem_reg_write,
    output logic        mem_regout
);
    logic [31:0] mem [DEPTH_WORDS];
    logic [ADDR_W-1:0] idx;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] load_val;
    logic        unused_bits;

    assign idx         = alu_result[ADDR_W+1:2];
    assign rdata       = mem[idx];
    assign unused_bits = ^{ex_mem_instruction, alu_result};

`ifdef MEM_BYTE_LANES_EN
    logic [2:0]  funct3;
    logic [31:0] shifted;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    assign funct3 = ex_mem_instruction[14:12];

    // store lane enables and replicated write data chosen by access size
    always_comb begin
        be    = funct3 == 3'b000 ? 4'b0001 << alu_result[1:0] :
                funct3 == 3'b001 ? (alu_result[1] ? 4'b1100 : 4'b0011) :
                funct3 == 3'b010 ? 4'b1111 : 4'b0000;
        wdata = funct3 == 3'b000 ? {4{rs2_data[7:0]}} :
                funct3 == 3'b001 ? {2{rs2_data[15:0]}} : rs2_data;
    end

    // lane-select and extend the addressed word for loads
    always_comb begin
        shifted  = rdata >> {alu_result[1:0], 3'b000};
        byte_val = shifted[7:0];
        half_val = alu_result[1] ? rdata[31:16] : rdata[15:0];
        load_val = funct3 == 3'b000 ? {{24{byte_val[7]}}, byte_val} :
                   funct3 == 3'b001 ? {{16{half_val[15]}}, half_val} :
                   funct3 == 3'b010 ? rdata :
                   funct3 == 3'b100 ? {24'b0, byte_val} :
                   funct3 == 3'b101 ? {16'b0, half_val} : 32'b0;
    end
`else
    // full-word access only, funct3 ignored
    always_comb begin
        be       = 4'b1111;
        wdata    = rs2_data;
        load_val = rdata;
    end
`endif

    // memory write; a store on an edge where reset is held is dropped
    always_ff @(posedge clk) begin
        if (rst && mem_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // MEM/WB pipeline register; load data reflects the pre-write word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_data       <= '0;
            mem_alu_result <= '0;
            mem_rd         <= '0;
            mem_reg_write  <= 1'b0;
            mem_regout     <= 1'b0;
        end else begin
            mem_data       <= mem_read ? load_val : 32'b0;
            mem_alu_result <= alu_result;
            mem_rd         <= rd;
            mem_reg_write  <= reg_write;
            mem_regout     <= mem_reg;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized check of mem_stage against a byte-addressed memory model
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] alu_result, rs2_data, ex_mem_instruction;
    logic [4:0]  rd;
    logic        reg_write, mem_write, mem_read, mem_reg;
    logic [31:0] mem_data, mem_alu_result;
    logic [4:0]  mem_rd;
    logic        mem_reg_write, mem_regout;

    mem_stage dut (
        .clk(clk), .rst(rst), .alu_result(alu_result), .rs2_data(rs2_data), .rd(rd),
        .reg_write(reg_write), .mem_write(mem_write), .mem_read(mem_read), .mem_reg(mem_reg),
        .ex_mem_instruction(ex_mem_instruction), .mem_data(mem_data),
        .mem_alu_result(mem_alu_result), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_regout(mem_regout)
    );

    always #5 clk = ~clk;

    logic [7:0] mb [4096];
    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [11:0] a);
        logic [11:0] w;
        w = {a[11:2], 2'b00};
        return {mb[w + 12'd3], mb[w + 12'd2], mb[w + 12'd1], mb[w]};
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a32, input logic [2:0] f3);
        logic [11:0] a;
        logic [7:0]  b;
        logic [15:0] h;
        a = a32[11:0];
        b = mb[a];
        h = {mb[{a[11:1], 1'b1}], mb[{a[11:1], 1'b0}]};
`ifdef MEM_BYTE_LANES_EN
        case (f3)
            3'd0: return {{24{b[7]}}, b};
            3'd1: return {{16{h[15]}}, h};
            3'd2: return word_at(a);
            3'd4: return {24'b0, b};
            3'd5: return {16'b0, h};
            default: return 32'b0;
        endcase
`else
        return word_at(a);
`endif
    endfunction

    task automatic model_store(input logic [31:0] a32, input logic [31:0] d, input logic [2:0] f3);
        logic [11:0] a;
        a = a32[11:0];
`ifdef MEM_BYTE_LANES_EN
        if (f3 == 3'd0) mb[a] = d[7:0];
        if (f3 == 3'd1) begin
            mb[{a[11:1], 1'b0}] = d[7:0];
            mb[{a[11:1], 1'b1}] = d[15:8];
        end
        if (f3 == 3'd2) for (int i = 0; i < 4; i++) mb[{a[11:2], 2'(i)}] = d[8*i +: 8];
`else
        for (int i = 0; i < 4; i++) mb[{a[11:2], 2'(i)}] = d[8*i +: 8];
`endif
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                      input logic we, input logic re, input string tag);
        logic [31:0] exp_d;
        logic [4:0]  r;
        logic        rw, mr;
        r  = 5'($urandom);
        rw = 1'($urandom);
        mr = 1'($urandom);
        alu_result = a; rs2_data = d; rd = r; reg_write = rw; mem_reg = mr;
        mem_write = we; mem_read = re;
        ex_mem_instruction = {17'($urandom), f3, 12'($urandom)};
        exp_d = re ? model_load(a, f3) : 32'b0;
        if (we) model_store(a, d, f3);
        @(posedge clk);
        #1;
        chk({tag, ".data"}, mem_data, exp_d);
        chk({tag, ".alu"}, mem_alu_result, a);
        chk({tag, ".rd"}, 32'(mem_rd), 32'(r));
        chk({tag, ".rw"}, 32'(mem_reg_write), 32'(rw));
        chk({tag, ".mr"}, 32'(mem_regout), 32'(mr));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".data"}, mem_data, 0);
        chk({tag, ".alu"}, mem_alu_result, 0);
        chk({tag, ".rd"}, 32'(mem_rd), 0);
        chk({tag, ".rw"}, 32'(mem_reg_write), 0);
        chk({tag, ".mr"}, 32'(mem_regout), 0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mb[i] = 8'h00;
        alu_result = 32'hFFFF_FFFF; rs2_data = 32'h1234_5678; rd = 5'd31;
        reg_write = 1'b1; mem_write = 1'b1; mem_read = 1'b1; mem_reg = 1'b1;
        ex_mem_instruction = 32'h0000_2000;
        #2;
        chk_zero("rst_async");
        @(posedge clk);
        #1;
        chk_zero("rst_edge");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 1024; i++) op(32'(i * 4), 32'h0, 3'd2, 1'b1, 1'b0, "clear");

        alu_result = 32'hDEAD_BEEF; rd = 5'd15; reg_write = 1'b1; mem_reg = 1'b1;
        mem_write = 1'b0; mem_read = 1'b0;
        @(posedge clk);
        #1;
        chk("pass.alu", mem_alu_result, 32'hDEAD_BEEF);
        chk("pass.rd", 32'(mem_rd), 32'd15);
        chk("pass.rw", 32'(mem_reg_write), 32'd1);
        chk("pass.mr", 32'(mem_regout), 32'd1);
        chk("pass.data", mem_data, 32'd0);

        op(32'h20, 32'hABCD_1234, 3'd2, 1'b1, 1'b0, "sw");
        op(32'h20, 32'h0, 3'd2, 1'b0, 1'b1, "lw");
        chk("spec_lw", mem_data, 32'hABCD_1234);
`ifdef MEM_BYTE_LANES_EN
        op(32'h20, 32'h0, 3'd2, 1'b1, 1'b0, "sw0");
        op(32'h21, 32'h80, 3'd0, 1'b1, 1'b0, "sb");
        op(32'h21, 32'h0, 3'd0, 1'b0, 1'b1, "lb");
        chk("spec_lb", mem_data, 32'hFFFF_FF80);
        op(32'h21, 32'h0, 3'd4, 1'b0, 1'b1, "lbu");
        chk("spec_lbu", mem_data, 32'h0000_0080);
        op(32'h20, 32'h0, 3'd2, 1'b0, 1'b1, "lw2");
        chk("spec_lw2", mem_data, 32'h0000_8000);
        op(32'h42, 32'hBEEF, 3'd1, 1'b1, 1'b0, "sh");
        op(32'h42, 32'h0, 3'd1, 1'b0, 1'b1, "lh");
        chk("spec_lh", mem_data, 32'hFFFF_BEEF);
        op(32'h42, 32'h0, 3'd5, 1'b0, 1'b1, "lhu");
        chk("spec_lhu", mem_data, 32'h0000_BEEF);
`endif
        op(32'h20, 32'h1111_1111, 3'd2, 1'b1, 1'b0, "sw1");
        op(32'h1020, 32'h2222_2222, 3'd2, 1'b1, 1'b1, "rw_same");
        chk("spec_old", mem_data, 32'h1111_1111);
        op(32'h20, 32'h0, 3'd2, 1'b0, 1'b1, "lw_wrap");
        chk("spec_new", mem_data, 32'h2222_2222);

        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            a = {$urandom_range(0, 7) == 0 ? 20'($urandom) : 20'h0, 6'h0, 6'($urandom)};
            op(a, $urandom, 3'($urandom), 1'($urandom), 1'($urandom), "rnd");
        end

        alu_result = 32'h30; rs2_data = 32'hCAFE_F00D; mem_write = 1'b1; mem_read = 1'b1;
        ex_mem_instruction = 32'h0000_2000;
        rst = 1'b0;
        #1;
        chk_zero("midrst_async");
        @(posedge clk);
        #1;
        chk_zero("midrst_edge");
        @(negedge clk);
        rst = 1'b1;
        mem_write = 1'b0;
        @(posedge clk);
        #1;
        op(32'h30, 32'h0, 3'd2, 1'b0, 1'b1, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
